// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports and the ALU/control-unit port of alu_arbiter.
// slave is the arbiter's view; master is the view of the clients and ALU that drive it.
interface alu_arbiter_if;
  logic        req0;
  logic        req1;
  logic [1:0]  opcode0;
  logic [1:0]  opcode1;
  logic [7:0]  a0;
  logic [7:0]  b0;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic [15:0] alu_result;
  logic        alu_done;

  logic        alu_begin_op;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] result0;
  logic [15:0] result1;
  logic        err0;
  logic        err1;
  logic        busy;

  modport slave (
    input  req0, req1, opcode0, opcode1, a0, b0, a1, b1, alu_result, alu_done,
    output alu_begin_op, alu_opcode, alu_a, alu_b, gnt0, gnt1, done0, done1,
           result0, result1, err0, err1, busy
  );

  modport master (
    output req0, req1, opcode0, opcode1, a0, b0, a1, b1, alu_result, alu_done,
    input  alu_begin_op, alu_opcode, alu_a, alu_b, gnt0, gnt1, done0, done1,
           result0, result1, err0, err1, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-client arbiter and sequencer for the shared 8-bit ALU.
// States: IDLE arbitrate | ISSUE begin strobe | WAIT latency/alu_done/timeout | RESP done pulse.
module alu_arbiter #(
  parameter int ADDSUB_LAT = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  localparam int MAX_LAT = (TIMEOUT > ADDSUB_LAT) ? TIMEOUT : ADDSUB_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] ADD_LAST = CW'(ADDSUB_LAT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_lp;
  logic          r_sel;
  logic          r_begin;
  logic [1:0]    r_op;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_done0;
  logic          r_done1;
  logic [15:0]   r_res0;
  logic [15:0]   r_res1;
  logic          r_err0;
  logic          r_err1;
  logic          r_busy;

  logic w_any;
  logic w_win;
  logic w_complete;
  logic w_timeout;

  // On a tie the requester that was not served last (r_lp) wins.
  assign w_any      = bus.req0 | bus.req1;
  assign w_win      = (bus.req0 & bus.req1) ? ~r_lp : bus.req1;
  assign w_complete = r_op[1] ? bus.alu_done : (r_cnt == ADD_LAST);
  assign w_timeout  = r_op[1] & ~bus.alu_done & (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lp    <= 1'b1;
      r_sel   <= 1'b0;
      r_begin <= 1'b0;
      r_op    <= 2'b00;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_res0  <= 16'h0000;
      r_res1  <= 16'h0000;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_begin <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_win;
            r_op    <= w_win ? bus.opcode1 : bus.opcode0;
            r_a     <= w_win ? bus.a1 : bus.a0;
            r_b     <= w_win ? bus.b1 : bus.b0;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_begin <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Exit always happens at or before TIMEOUT-1, so the counter never wraps.
          r_cnt <= r_cnt + 1'b1;
          if (w_complete) begin
            r_state <= S_RESP;
            if (r_sel) begin
              r_done1 <= 1'b1;
              r_res1  <= bus.alu_result;
              r_err1  <= 1'b0;
            end else begin
              r_done0 <= 1'b1;
              r_res0  <= bus.alu_result;
              r_err0  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state <= S_RESP;
            if (r_sel) begin
              r_done1 <= 1'b1;
              r_err1  <= 1'b1;
            end else begin
              r_done0 <= 1'b1;
              r_err0  <= 1'b1;
            end
          end
        end
        S_RESP: begin
          r_lp    <= r_sel;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_begin_op = r_begin;
  assign bus.alu_opcode   = r_op;
  assign bus.alu_a        = r_a;
  assign bus.alu_b        = r_b;
  assign bus.gnt0         = r_gnt0;
  assign bus.gnt1         = r_gnt1;
  assign bus.done0        = r_done0;
  assign bus.done1        = r_done1;
  assign bus.result0      = r_res0;
  assign bus.result1      = r_res1;
  assign bus.err0         = r_err0;
  assign bus.err1         = r_err1;
  assign bus.busy         = r_busy;

endmodule
